// File: rtl/counter_impl.sv
// ---------------------------------------------------------------------------
// counter_impl
//
// Per-channel time-tag counter. Tag words from the tag-stream decoder are
// buffered in an input FIFO and consumed one word per cycle. Tags are counted
// per channel over consecutive fixed-length windows. Each completed window is
// published on count_data together with a one-cycle count_valid strobe.
//
// State     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | not counting; FIFO words are popped and discarded
// S_ARMED   | window length latched; waiting for the first tag, which opens
//           | the first window at that tag's time
// S_COUNTING| counting tags into the current window, closing windows as
//           | later tags arrive
//
// Ports
//   clk             clock
//   rst             asynchronous active-high reset
//   valid_tag       per-lane valid, bit i qualifies lane i
//   tagtime         lane i timestamp at [i*TAG_WIDTH +: TAG_WIDTH]
//   channel         lane i channel ID at [i*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   window_size     window length in tag time units (latched on start)
//   start_counting  one-cycle pulse, arms counting from S_IDLE
//   reset_counting  one-cycle pulse, returns to S_IDLE and clears counters
//   count_data      per-channel counts of the last completed window
//   count_valid     one-cycle strobe, count_data has just been updated
// ---------------------------------------------------------------------------
module counter_impl #(
    parameter int TAG_WIDTH        = 64,
    parameter int NUM_OF_TAGS      = 4,
    parameter int CHANNEL_WIDTH    = 6,
    parameter int WINDOW_WIDTH     = 64,
    parameter int NUM_OF_CHANNELS  = 4,
    parameter int COUNTER_WIDTH    = 32,
    parameter int INPUT_FIFO_DEPTH = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_OF_TAGS-1:0]           valid_tag,
    input  logic [TAG_WIDTH*NUM_OF_TAGS-1:0] tagtime,
    input  logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] channel,
    input  logic [WINDOW_WIDTH-1:0]          window_size,
    input  logic                             start_counting,
    input  logic                             reset_counting,
    output logic [COUNTER_WIDTH-1:0]         count_data [NUM_OF_CHANNELS],
    output logic                             count_valid
);

    // FIFO depth is expected to be a power of two (pointer wrap relies on it).
    localparam int AW = $clog2(INPUT_FIFO_DEPTH);
    localparam int IW = $clog2(NUM_OF_TAGS + 1);
    localparam int SW = COUNTER_WIDTH + IW;
    localparam logic [SW-1:0] CNT_MAX = SW'({COUNTER_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COUNTING
    } state_t;

    // -----------------------------------------------------------------------
    // Input FIFO
    // -----------------------------------------------------------------------
    logic [NUM_OF_TAGS-1:0]               r_mem_valid [INPUT_FIFO_DEPTH];
    logic [TAG_WIDTH*NUM_OF_TAGS-1:0]     r_mem_time  [INPUT_FIFO_DEPTH];
    logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] r_mem_chan  [INPUT_FIFO_DEPTH];
    logic [AW:0]                          r_wr_ptr;
    logic [AW:0]                          r_rd_ptr;

    logic                                 w_empty;
    logic                                 w_full;
    logic                                 w_wr_en;
    logic                                 w_pop;
    logic [NUM_OF_TAGS-1:0]               w_head_valid;
    logic [TAG_WIDTH*NUM_OF_TAGS-1:0]     w_head_time;
    logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] w_head_chan;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // All-invalid words carry nothing; words arriving while full are dropped.
    assign w_wr_en = (|valid_tag) && !w_full;

    assign w_head_valid = r_mem_valid[r_rd_ptr[AW-1:0]];
    assign w_head_time  = r_mem_time[r_rd_ptr[AW-1:0]];
    assign w_head_chan  = r_mem_chan[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_valid[r_wr_ptr[AW-1:0]] <= valid_tag;
            r_mem_time[r_wr_ptr[AW-1:0]]  <= tagtime;
            r_mem_chan[r_wr_ptr[AW-1:0]]  <= channel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Window / counter state
    // -----------------------------------------------------------------------
    state_t                   r_state;
    logic [TAG_WIDTH-1:0]     r_window;
    logic [TAG_WIDTH-1:0]     r_win_end;
    // Lanes of the head word already consumed before a window close.
    logic [NUM_OF_TAGS-1:0]   r_done_mask;
    logic [COUNTER_WIDTH-1:0] r_cnt        [NUM_OF_CHANNELS];
    logic [COUNTER_WIDTH-1:0] r_count_data [NUM_OF_CHANNELS];
    logic                     r_count_valid;

    logic [NUM_OF_TAGS-1:0]   w_lane_v;
    logic [TAG_WIDTH-1:0]     w_lt [NUM_OF_TAGS];
    logic [CHANNEL_WIDTH-1:0] w_lc [NUM_OF_TAGS];
    logic [TAG_WIDTH-1:0]     w_first_t;
    logic [TAG_WIDTH-1:0]     w_end_base;
    logic [NUM_OF_TAGS-1:0]   w_hit;
    logic                     w_close;
    logic [IW-1:0]            w_inc     [NUM_OF_CHANNELS];
    logic [SW-1:0]            w_sum     [NUM_OF_CHANNELS];
    logic [COUNTER_WIDTH-1:0] w_cnt_sat [NUM_OF_CHANNELS];

    state_t                   w_state_nxt;
    logic                     w_proc;
    logic                     w_strobe;
    logic                     w_latch_win;
    logic [COUNTER_WIDTH-1:0] w_cnt_nxt [NUM_OF_CHANNELS];
    logic [NUM_OF_TAGS-1:0]   w_done_nxt;
    logic [TAG_WIDTH-1:0]     w_win_end_nxt;

    // Lane evaluation of the head word against the current window end.
    always_comb begin
        w_lane_v = w_head_valid & ~r_done_mask;
        for (int i = 0; i < NUM_OF_TAGS; i++) begin
            w_lt[i] = w_head_time[i*TAG_WIDTH +: TAG_WIDTH];
            w_lc[i] = w_head_chan[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end

        // Earliest valid lane; only meaningful in S_ARMED where it opens
        // the first window.
        w_first_t = '0;
        for (int i = NUM_OF_TAGS-1; i >= 0; i--) begin
            if (w_lane_v[i]) w_first_t = w_lt[i];
        end

        w_end_base = (r_state == S_ARMED) ? (w_first_t + r_window) : r_win_end;

        // Lanes are time-ordered, so everything after the first lane at or
        // past the window end belongs to a later window.
        w_hit   = '0;
        w_close = 1'b0;
        for (int i = 0; i < NUM_OF_TAGS; i++) begin
            if (w_lane_v[i]) begin
                if (!w_close && (w_lt[i] >= w_end_base)) w_close = 1'b1;
                if (!w_close) w_hit[i] = 1'b1;
            end
        end

        for (int c = 0; c < NUM_OF_CHANNELS; c++) begin
            w_inc[c] = '0;
            for (int i = 0; i < NUM_OF_TAGS; i++) begin
                if (w_hit[i] && (w_lc[i] == CHANNEL_WIDTH'(c)))
                    w_inc[c] = w_inc[c] + IW'(1);
            end
            w_sum[c]     = SW'(r_cnt[c]) + SW'(w_inc[c]);
            w_cnt_sat[c] = (w_sum[c] > CNT_MAX) ? {COUNTER_WIDTH{1'b1}}
                                                 : w_sum[c][COUNTER_WIDTH-1:0];
        end
    end

    // Next-state and register-update decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_proc        = 1'b0;
        w_pop         = 1'b0;
        w_strobe      = 1'b0;
        w_latch_win   = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = r_done_mask;
        w_win_end_nxt = r_win_end;

        if (reset_counting) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '{default: '0};
            w_done_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_pop = !w_empty;
                    if (start_counting) begin
                        w_state_nxt = S_ARMED;
                        w_latch_win = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (r_window == '0) begin
                        w_state_nxt = S_IDLE;
                    end else if (!w_empty) begin
                        w_proc      = 1'b1;
                        w_state_nxt = S_COUNTING;
                    end
                end
                S_COUNTING: begin
                    w_proc = !w_empty;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        if (w_proc) begin
            if (w_close) begin
                // Publish, restart counters, keep the word for the next window.
                w_strobe      = 1'b1;
                w_cnt_nxt     = '{default: '0};
                w_done_nxt    = r_done_mask | w_hit;
                w_win_end_nxt = w_end_base + r_window;
            end else begin
                w_cnt_nxt     = w_cnt_sat;
                w_pop         = 1'b1;
                w_done_nxt    = '0;
                w_win_end_nxt = w_end_base;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_window      <= '0;
            r_win_end     <= '0;
            r_done_mask   <= '0;
            r_cnt         <= '{default: '0};
            r_count_data  <= '{default: '0};
            r_count_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_end   <= w_win_end_nxt;
            r_done_mask <= w_done_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_latch_win) r_window <= TAG_WIDTH'(window_size);
            r_count_valid <= w_strobe;
            if (w_strobe) r_count_data <= w_cnt_sat;
        end
    end

    assign count_data  = r_count_data;
    assign count_valid = r_count_valid;

endmodule

// File: tb/tb_counter_impl.sv
module tb_counter_impl;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid_tag;
    logic [255:0] tagtime;
    logic [23:0]  channel;
    logic [63:0]  window_size;
    logic         start_counting;
    logic         reset_counting;
    logic [31:0]  cd   [4];
    logic         cv;
    logic [3:0]   cd_s [4];
    logic         cv_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] obs_q[$];
    int           obs_cyc[$];
    logic [127:0] exp_q[$];

    // reference model state for the random stream
    logic         m_started;
    logic [63:0]  m_end;
    logic [63:0]  m_w;
    int           m_cnt [4];

    counter_impl dut (
        .clk(clk), .rst(rst), .valid_tag(valid_tag), .tagtime(tagtime),
        .channel(channel), .window_size(window_size),
        .start_counting(start_counting), .reset_counting(reset_counting),
        .count_data(cd), .count_valid(cv)
    );

    counter_impl #(.COUNTER_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .valid_tag(valid_tag), .tagtime(tagtime),
        .channel(channel), .window_size(window_size),
        .start_counting(start_counting), .reset_counting(reset_counting),
        .count_data(cd_s), .count_valid(cv_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cv) begin
            obs_q.push_back({cd[3], cd[2], cd[1], cd[0]});
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [127:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endfunction

    function automatic logic [127:0] got(input int k);
        if (k < obs_q.size()) return obs_q[k];
        return '1;
    endfunction

    function automatic int got_cyc(input int k);
        if (k < obs_cyc.size()) return obs_cyc[k];
        return -1000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [3:0] v,
                        input logic [63:0] t0, input logic [63:0] t1,
                        input logic [63:0] t2, input logic [63:0] t3,
                        input logic [5:0] c0, input logic [5:0] c1,
                        input logic [5:0] c2, input logic [5:0] c3);
        valid_tag = v;
        tagtime   = {t3, t2, t1, t0};
        channel   = {c3, c2, c1, c0};
        tick();
        valid_tag = '0;
    endtask

    task automatic send1(input logic [63:0] t, input logic [5:0] c);
        send(4'b0001, t, 64'd0, 64'd0, 64'd0, c, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic pulse_start();
        start_counting = 1'b1;
        tick();
        start_counting = 1'b0;
    endtask

    task automatic pulse_rc();
        reset_counting = 1'b1;
        tick();
        reset_counting = 1'b0;
    endtask

    task automatic model_tag(input logic [63:0] t, input int c);
        if (!m_started) begin
            m_started = 1'b1;
            m_end     = t + m_w;
        end
        while (t >= m_end) begin
            exp_q.push_back(pk(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]));
            m_cnt = '{default: 0};
            m_end = m_end + m_w;
        end
        if (c < 4) m_cnt[c]++;
    endtask

    initial begin
        logic [63:0] t;
        logic [63:0] t2;
        logic [3:0]  v;
        logic [63:0] tt [4];
        logic [5:0]  cc [4];
        int          c_close;
        int          nobs;

        rst = 1'b1;
        valid_tag = '0;
        tagtime = '0;
        channel = '0;
        window_size = 64'd100;
        start_counting = 1'b0;
        reset_counting = 1'b0;
        idle(3);
        chk("reset_valid", 128'(cv), 128'd0);
        chk("reset_data", {cd[3], cd[2], cd[1], cd[0]}, 128'd0);
        chk("reset_data_sat", 128'({cd_s[3], cd_s[2], cd_s[1], cd_s[0]}), 128'd0);
        rst = 1'b0;
        idle(2);

        // tags without start_counting are discarded
        send1(64'd100, 6'd0);
        send(4'b1111, 64'd200, 64'd210, 64'd220, 64'd230, 6'd0, 6'd1, 6'd2, 6'd3);
        send1(64'd900, 6'd1);
        idle(10);
        chk("idle_no_strobe", 128'(obs_q.size()), 128'd0);
        chk("idle_data", {cd[3], cd[2], cd[1], cd[0]}, 128'd0);

        // basic window W=100
        window_size = 64'd100;
        pulse_start();
        send1(64'd1000, 6'd0);
        send1(64'd1050, 6'd1);
        pulse_start();                     // ignored while counting
        send1(64'd1099, 6'd1);
        send1(64'd1100, 6'd2);
        c_close = cyc;
        idle(8);
        chk("basic_count", 128'(obs_q.size()), 128'd1);
        chk("basic_win0", got(0), pk(1, 2, 0, 0));
        chk("basic_latency_ok", 128'((got_cyc(0) - c_close) >= 1 && (got_cyc(0) - c_close) <= 5), 128'd1);
        chk("basic_hold", {cd[3], cd[2], cd[1], cd[0]}, pk(1, 2, 0, 0));
        send1(64'd1200, 6'd0);
        idle(6);
        chk("basic_count2", 128'(obs_q.size()), 128'd2);
        chk("basic_win1", got(1), pk(0, 0, 1, 0));
        pulse_rc();
        idle(3);
        chk("rc_keeps_data", {cd[3], cd[2], cd[1], cd[0]}, pk(0, 0, 1, 0));

        // multi-lane split W=50, plus out-of-range channel 5
        obs_q.delete();
        obs_cyc.delete();
        window_size = 64'd50;
        pulse_start();
        send(4'b1111, 64'd0, 64'd10, 64'd60, 64'd70, 6'd3, 6'd3, 6'd0, 6'd0);
        send1(64'd80, 6'd5);
        send1(64'd120, 6'd1);
        idle(8);
        chk("split_count", 128'(obs_q.size()), 128'd2);
        chk("split_win0", got(0), pk(0, 0, 0, 2));
        chk("split_win1_ch5_ignored", got(1), pk(2, 0, 0, 0));

        // empty windows W=100
        pulse_rc();
        obs_q.delete();
        obs_cyc.delete();
        window_size = 64'd100;
        pulse_start();
        send1(64'd0, 6'd0);
        send1(64'd350, 6'd2);
        idle(10);
        chk("empty_count", 128'(obs_q.size()), 128'd3);
        chk("empty_win0", got(0), pk(1, 0, 0, 0));
        chk("empty_win1", got(1), pk(0, 0, 0, 0));
        chk("empty_win2", got(2), pk(0, 0, 0, 0));
        chk("empty_consec1", 128'(got_cyc(1) - got_cyc(0)), 128'd1);
        chk("empty_consec2", 128'(got_cyc(2) - got_cyc(1)), 128'd1);
        send1(64'd400, 6'd1);
        idle(6);
        chk("empty_count2", 128'(obs_q.size()), 128'd4);
        chk("empty_win3", got(3), pk(0, 0, 1, 0));

        // reset_counting wins over simultaneous start_counting
        pulse_rc();
        obs_q.delete();
        obs_cyc.delete();
        start_counting = 1'b1;
        reset_counting = 1'b1;
        tick();
        start_counting = 1'b0;
        reset_counting = 1'b0;
        send1(64'd10, 6'd0);
        send1(64'd500, 6'd0);
        idle(8);
        chk("rc_beats_start", 128'(obs_q.size()), 128'd0);

        // zero window returns to idle
        window_size = 64'd0;
        pulse_start();
        send1(64'd10, 6'd0);
        send1(64'd20, 6'd0);
        send1(64'd500, 6'd1);
        idle(8);
        chk("zero_window", 128'(obs_q.size()), 128'd0);

        // saturation: 20 ch0 tags, 4-bit instance saturates at 15
        pulse_rc();
        obs_q.delete();
        obs_cyc.delete();
        window_size = 64'd1000;
        pulse_start();
        for (int k = 0; k < 5; k++)
            send(4'b1111, 64'(10 + 4*k), 64'(11 + 4*k), 64'(12 + 4*k), 64'(13 + 4*k),
                 6'd0, 6'd0, 6'd0, 6'd0);
        send1(64'd2000, 6'd1);
        idle(8);
        chk("sat_count", 128'(obs_q.size()), 128'd1);
        chk("sat_wide", got(0), pk(20, 0, 0, 0));
        chk("sat_narrow", 128'({cd_s[3], cd_s[2], cd_s[1], cd_s[0]}), 128'h000F);

        // random stream against reference model, W=50000
        pulse_rc();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        m_started = 1'b0;
        m_end = '0;
        m_w = 64'd50000;
        m_cnt = '{default: 0};
        window_size = m_w;
        pulse_start();
        t = 64'd5000000;
        for (int n = 0; n < 2500; n++) begin
            if (n == 1200) begin
                idle(2000);
                t = t + 64'd180000;
            end
            v = 4'($urandom_range(0, 15));
            for (int l = 0; l < 4; l++) begin
                if (v[l]) begin
                    t = t + 64'($urandom_range(0, 200));
                    tt[l] = t;
                    cc[l] = 6'($urandom_range(0, 3));
                    model_tag(t, int'(cc[l]));
                end else begin
                    tt[l] = {$urandom, $urandom};
                    cc[l] = 6'($urandom_range(0, 63));
                end
            end
            valid_tag = v;
            tagtime = {tt[3], tt[2], tt[1], tt[0]};
            channel = {cc[3], cc[2], cc[1], cc[0]};
            tick();
        end
        valid_tag = '0;
        idle(20);
        chk("rand_count", 128'(obs_q.size()), 128'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("rand_win%0d", k), got(k), exp_q[k]);

        // reset_counting mid-window: no partial strobe, counters cleared
        nobs = obs_q.size();
        pulse_rc();
        send1(t + 64'd500000, 6'd0);
        idle(10);
        chk("rc_no_partial", 128'(obs_q.size()), 128'(nobs));
        t2 = t + 64'd1000000;
        window_size = 64'd100;
        pulse_start();
        send1(t2, 6'd3);
        send1(t2 + 64'd100, 6'd0);
        idle(6);
        chk("rc_restart_count", 128'(obs_q.size()), 128'(nobs + 1));
        chk("rc_restart_win", got(nobs), pk(0, 0, 0, 1));

        // asynchronous rst mid-operation
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_data", {cd[3], cd[2], cd[1], cd[0]}, 128'd0);
        chk("async_rst_valid", 128'(cv), 128'd0);
        #1;
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
